uart_io_bridge: RTL and testbench
=================================

UART_IO_BRIDGE -- requirements
Module: uart_io_bridge

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk100 cycles per UART bit (115200 baud at 100 MHz); legal range 4..65535.
REQ-002 Parameter TX_FIFO_DEPTH, default 8, TX FIFO entries; power of two, at least 2.
REQ-003 clk100  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 IO_port_ID  in  8  processor IO port address.
REQ-006 IO_write_data  in  8  processor write data.
REQ-007 IO_write_strobe  in  1  one-cycle write qualifier.
REQ-008 IO_read_strobe  in  1  one-cycle read qualifier.
REQ-009 IO_read_data  out  8  read data returned to the processor.
REQ-010 uart_rxd  in  1  asynchronous serial input; idle high.
REQ-011 uart_txd  out  1  serial output; idle high.

Function
REQ-012 Port map is as follows:
- 0x01 write: push TX FIFO.
- 0x01 read: RX data.
- 0x02 read: 0xFF when RX holding register is valid, else 0x00.
- 0x03 read: 0xFF when TX FIFO is full, else 0x00.
- 0x04 read: status {6'b0, frame_err, rx_overrun}.
- Any other port reads 0x00; writes to it are ignored.
REQ-013 IO_read_data SHALL be combinational from IO_port_ID and current state, independent of IO_read_strobe.
REQ-014 Read side effects occur at the clock edge where IO_read_strobe=1:
- Port 0x01 clears rx_valid.
- Port 0x04 clears frame_err and rx_overrun.
REQ-015 A write to 0x01 with the FIFO full (evaluated before any same-cycle pop) SHALL be dropped without changing FIFO contents.
REQ-016 TX FSM states IDLE, START, DATA, STOP:
- IDLE exits to START when the FIFO is non-empty, popping one byte in that cycle.
- START, DATA and STOP bits each last exactly CLKS_PER_BIT cycles.
- Data is sent LSB first, 8 bits.
- STOP drives 1, then returns to IDLE.
REQ-017 Back-to-back frames: a non-empty FIFO at STOP end SHALL start the next START with no idle gap beyond one cycle.
REQ-018 uart_rxd SHALL pass through a 2-flop synchronizer before any use.
REQ-019 RX FSM states IDLE, START, DATA, STOP:
- A falling edge in IDLE enters START.
- At CLKS_PER_BIT/2 the line is sampled: low proceeds to DATA; high returns to IDLE (glitch).
- The 8 DATA bits are sampled at mid-bit, each CLKS_PER_BIT apart, LSB first.
REQ-020 At STOP mid-bit, line high loads the byte into the holding register and sets rx_valid; line low discards the byte and sets frame_err.
REQ-021 Loading a byte while rx_valid=1 and no same-cycle 0x01 read SHALL overwrite the data and set rx_overrun.
REQ-022 A 0x01 read in the same cycle as a load SHALL leave rx_valid=1 with the new byte and SHALL NOT set rx_overrun.
REQ-023 FIFO pointers SHALL wrap modulo TX_FIFO_DEPTH; full/empty are tracked with an occupancy count 0..TX_FIFO_DEPTH.
REQ-024 A simultaneous push and pop on a non-full FIFO SHALL leave occupancy unchanged.

Reset
REQ-025 With reset=1 at a clock edge, these take their reset values at that edge:
- TX and RX FSMs = IDLE.
- FIFO occupancy 0.
- rx_valid, rx_overrun, frame_err = 0.
- Baud counters 0.
- uart_txd = 1.
- Synchronizer flops = 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame and return uart_txd high at that same edge; a partial RX byte SHALL be discarded.

Structure
REQ-027 Shared package uart_io_pkg holds the port-ID constants 0x01..0x04 and the TX/RX state encodings.
REQ-028 The TX FIFO is a sub-module, uart_tx_fifo, with push/pop/full/empty/data ports.
REQ-029 All remaining logic stays in uart_io_bridge.

Verification
REQ-030 The bench SHALL run with CLKS_PER_BIT=4 and cover these scenarios:
- Write 0x55 to port 0x01 -> uart_txd shows 0, then 1,0,1,0,1,0,1,0, then 1, each held 4 cycles.
- 9 back-to-back writes with DEPTH=8 while the transmitter is busy on byte 0 -> port 0x03 reads 0xFF, the 9th byte is dropped, and exactly 8 frames appear on uart_txd.
- Drive frame 0xA3 on uart_rxd -> port 0x02 reads 0xFF; a 0x01 read returns 0xA3; port 0x02 then reads 0x00.
- Two frames 0x11, 0x22 with no read between -> 0x01 reads 0x22; port 0x04 reads 0x01; a second 0x04 read returns 0x00.
- Frame with stop bit 0 -> rx_valid stays 0 and port 0x04 reads 0x02.
- A 2-cycle low glitch on uart_rxd -> no byte is received. Reset asserted mid-TX-frame -> uart_txd is high at that edge and the FIFO is empty.

Source files
------------

// File: rtl/uart_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_io_pkg
// Description : Shared IO port addresses and UART FSM state encodings for
//               the UART IO bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_io_pkg;

    // Processor IO port addresses
    localparam logic [7:0] c_port_data    = 8'h01;
    localparam logic [7:0] c_port_rx_rdy  = 8'h02;
    localparam logic [7:0] c_port_tx_full = 8'h03;
    localparam logic [7:0] c_port_status  = 8'h04;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Small first-word-fall-through FIFO feeding the UART
//               transmitter. Occupancy count drives full/empty.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Full is judged on the pre-pop count, so a push into a full FIFO is
    // dropped even if the same cycle pops.
    assign o_full  = (r_count == c_depth);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage array; no reset needed since reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_io_bridge
// Description : 8N1 UART attached to a processor IO port bus. Writes to port
//               0x01 queue bytes for transmission; reads return received
//               data and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_io_bridge
    import uart_io_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 868,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic       clk100,
    input  logic       reset,
    input  logic [7:0] IO_port_ID,
    input  logic [7:0] IO_write_data,
    input  logic       IO_write_strobe,
    input  logic       IO_read_strobe,
    output logic [7:0] IO_read_data,
    input  logic       uart_rxd,
    output logic       uart_txd
);

    localparam logic [15:0] c_bit_last  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] c_half_last = 16'(CLKS_PER_BIT / 2 - 1);

    // ---------------- TX path ----------------
    tx_state_t   r_tx_state, w_tx_state_next;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_bit, w_tx_bit_next;
    logic [7:0]  r_tx_shift, w_tx_shift_next;
    logic        r_txd, w_txd_next;
    logic        w_tx_pop, w_tx_push, w_tx_bit_end;
    logic [7:0]  w_fifo_data;
    logic        w_fifo_full, w_fifo_empty;

    assign w_tx_push    = IO_write_strobe && (IO_port_ID == c_port_data);
    assign w_tx_bit_end = (r_tx_cnt == c_bit_last);
    assign uart_txd     = r_txd;

    uart_tx_fifo #(
        .DEPTH (TX_FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk     (clk100),
        .rst     (reset),
        .i_push  (w_tx_push),
        .i_data  (IO_write_data),
        .i_pop   (w_tx_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // TX next state: STOP chains straight into START when more data waits.
    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_shift_next = r_tx_shift;
        w_tx_bit_next   = r_tx_bit;
        w_tx_pop        = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (!w_fifo_empty) begin
                    w_tx_pop        = 1'b1;
                    w_tx_shift_next = w_fifo_data;
                    w_tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (w_tx_bit_end) begin
                    w_tx_bit_next   = 3'd0;
                    w_tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (w_tx_bit_end) begin
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_next = TX_STOP;
                    end else begin
                        w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
                        w_tx_bit_next   = r_tx_bit + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (w_tx_bit_end) begin
                    if (!w_fifo_empty) begin
                        w_tx_pop        = 1'b1;
                        w_tx_shift_next = w_fifo_data;
                        w_tx_state_next = TX_START;
                    end else begin
                        w_tx_state_next = TX_IDLE;
                    end
                end
            end
            default: w_tx_state_next = TX_IDLE;
        endcase
    end

    // Line level follows the state being entered so uart_txd is a clean flop.
    assign w_txd_next = (w_tx_state_next == TX_START) ? 1'b0 :
                        (w_tx_state_next == TX_DATA)  ? w_tx_shift_next[0] : 1'b1;

    // TX state, bit timer and shift register.
    always_ff @(posedge clk100) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_shift <= w_tx_shift_next;
            r_tx_bit   <= w_tx_bit_next;
            r_txd      <= w_txd_next;
            if ((r_tx_state == TX_IDLE) || w_tx_bit_end) r_tx_cnt <= '0;
            else                                          r_tx_cnt <= r_tx_cnt + 16'd1;
        end
    end

    // ---------------- RX path ----------------
    rx_state_t   r_rx_state, w_rx_state_next;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit, w_rx_bit_next;
    logic [7:0]  r_rx_shift, w_rx_shift_next;
    logic        r_rxd_meta, r_rxd_sync, r_rxd_prev;
    logic        w_rx_sample, w_rx_load, w_rx_frame_bad;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid, r_rx_overrun, r_frame_err;
    logic        w_rd_data, w_rd_status;

    // The start bit is checked half a bit in; later samples are a full bit apart.
    assign w_rx_sample = (r_rx_state == RX_START) ? (r_rx_cnt == c_half_last)
                                                  : (r_rx_cnt == c_bit_last);
    assign w_rd_data   = IO_read_strobe && (IO_port_ID == c_port_data);
    assign w_rd_status = IO_read_strobe && (IO_port_ID == c_port_status);

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge clk100) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    // RX next state: glitch rejection at start, LSB-first assembly, stop check.
    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_shift_next = r_rx_shift;
        w_rx_bit_next   = r_rx_bit;
        w_rx_load       = 1'b0;
        w_rx_frame_bad  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rxd_prev && !r_rxd_sync) w_rx_state_next = RX_START;
            end
            RX_START: begin
                if (w_rx_sample) begin
                    w_rx_bit_next   = 3'd0;
                    w_rx_state_next = r_rxd_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rx_sample) begin
                    w_rx_shift_next = {r_rxd_sync, r_rx_shift[7:1]};
                    w_rx_bit_next   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) w_rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_rx_sample) begin
                    w_rx_load       = r_rxd_sync;
                    w_rx_frame_bad  = !r_rxd_sync;
                    w_rx_state_next = RX_IDLE;
                end
            end
            default: w_rx_state_next = RX_IDLE;
        endcase
    end

    // RX state, bit timer and shift register.
    always_ff @(posedge clk100) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_state_next;
            r_rx_shift <= w_rx_shift_next;
            r_rx_bit   <= w_rx_bit_next;
            if ((r_rx_state == RX_IDLE) || w_rx_sample) r_rx_cnt <= '0;
            else                                         r_rx_cnt <= r_rx_cnt + 16'd1;
        end
    end

    // Holding register and sticky flags; a same-cycle data read absorbs a load.
    always_ff @(posedge clk100) begin
        if (reset) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (w_rx_load)      r_rx_data  <= r_rx_shift;
            if (w_rx_load)      r_rx_valid <= 1'b1;
            else if (w_rd_data) r_rx_valid <= 1'b0;
            r_rx_overrun <= (r_rx_overrun && !w_rd_status) ||
                            (w_rx_load && r_rx_valid && !w_rd_data);
            r_frame_err  <= (r_frame_err && !w_rd_status) || w_rx_frame_bad;
        end
    end

    // Read mux is purely a function of the addressed port and current state.
    always_comb begin
        IO_read_data = 8'h00;
        case (IO_port_ID)
            c_port_data:    IO_read_data = r_rx_data;
            c_port_rx_rdy:  IO_read_data = {8{r_rx_valid}};
            c_port_tx_full: IO_read_data = {8{w_fifo_full}};
            c_port_status:  IO_read_data = {6'b0, r_frame_err, r_rx_overrun};
            default:        IO_read_data = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_io_bridge
// Description : Scoreboard bench for uart_io_bridge with CLKS_PER_BIT=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_io_bridge;

    localparam int CLKS  = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CLKS;

    logic       clk100 = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] IO_port_ID = 8'h00;
    logic [7:0] IO_write_data = 8'h00;
    logic       IO_write_strobe = 1'b0;
    logic       IO_read_strobe = 1'b0;
    logic [7:0] IO_read_data;
    logic       uart_rxd = 1'b1;
    logic       uart_txd;

    uart_io_bridge #(
        .CLKS_PER_BIT  (CLKS),
        .TX_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk100          (clk100),
        .reset           (reset),
        .IO_port_ID      (IO_port_ID),
        .IO_write_data   (IO_write_data),
        .IO_write_strobe (IO_write_strobe),
        .IO_read_strobe  (IO_read_strobe),
        .IO_read_data    (IO_read_data),
        .uart_rxd        (uart_rxd),
        .uart_txd        (uart_txd)
    );

    always #5 clk100 = ~clk100;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] tx_q[$];
    int         tx_level = 0;
    int         frames_started = 0;
    int         frames_done = 0;
    logic [7:0] m_rx_data = 8'h00;
    logic       m_rx_valid = 1'b0;
    logic       m_overrun = 1'b0;
    logic       m_frame_err = 1'b0;
    logic       m_rx_seen = 1'b0;

    typedef struct {
        logic [7:0] port;
        logic [7:0] exp;
    } rd_t;
    rd_t rd_q[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] port);
        case (port)
            8'h01:   return m_rx_data;
            8'h02:   return m_rx_valid ? 8'hFF : 8'h00;
            8'h03:   return (tx_level == DEPTH) ? 8'hFF : 8'h00;
            8'h04:   return {6'b0, m_frame_err, m_overrun};
            default: return 8'h00;
        endcase
    endfunction

    // Line waveform of one 8N1 frame, one entry per clock
    function automatic logic [FRAME-1:0] frame_shape(input logic [7:0] b);
        logic [FRAME-1:0] f;
        for (int i = 0; i < FRAME; i++) begin
            if (i < CLKS)           f[i] = 1'b0;
            else if (i < 9 * CLKS)  f[i] = b[(i - CLKS) / CLKS];
            else                    f[i] = 1'b1;
        end
        return f;
    endfunction

    function automatic void model_push(input logic [7:0] port, input logic [7:0] data);
        if (port == 8'h01 && tx_level < DEPTH) begin
            tx_q.push_back(data);
            tx_level++;
        end
    endfunction

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic do_write(input logic [7:0] port, input logic [7:0] data);
        IO_port_ID      = port;
        IO_write_data   = data;
        IO_write_strobe = 1'b1;
        model_push(port, data);
        tick();
        IO_write_strobe = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] port);
        rd_t e;
        e.port = port;
        e.exp  = model_read(port);
        rd_q.push_back(e);
        IO_port_ID     = port;
        IO_read_strobe = 1'b1;
        tick();
        IO_read_strobe = 1'b0;
        if (port == 8'h01) m_rx_valid = 1'b0;
        if (port == 8'h04) begin
            m_overrun   = 1'b0;
            m_frame_err = 1'b0;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_ok);
        uart_rxd = 1'b0;
        repeat (CLKS) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CLKS) tick();
        end
        uart_rxd = stop_ok;
        repeat (CLKS) tick();
        uart_rxd = 1'b1;
        repeat (3) tick();
        if (stop_ok) begin
            if (m_rx_valid) m_overrun = 1'b1;
            m_rx_valid = 1'b1;
            m_rx_data  = b;
            m_rx_seen  = 1'b1;
        end else begin
            m_frame_err = 1'b1;
        end
    endtask

    task automatic wait_started(input int target, input int budget, input string name);
        int n = 0;
        while (frames_started < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(frames_started), 64'(target));
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (frames_done < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(frames_done), 64'(target));
    endtask

    // Read monitor: every strobed read is scored against the queued expectation
    initial begin
        rd_t e;
        forever begin
            @(negedge clk100);
            if (IO_read_strobe) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 64'(1), 64'(0));
                end else begin
                    e = rd_q.pop_front();
                    check($sformatf("rd_port_%02h", e.port), 64'(IO_read_data), 64'(e.exp));
                end
            end
        end
    end

    // TX monitor: captures each frame cycle by cycle and compares whole waveform
    initial begin
        logic             prev;
        logic             aborted;
        logic [FRAME-1:0] act;
        logic [7:0]       b;
        prev = 1'b1;
        forever begin
            @(negedge clk100);
            if (reset) begin
                prev = 1'b1;
            end else if (prev && !uart_txd) begin
                frames_started++;
                if (tx_level > 0) tx_level--;
                act     = '0;
                aborted = 1'b0;
                for (int i = 1; i < FRAME; i++) begin
                    @(negedge clk100);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    act[i] = uart_txd;
                end
                if (!aborted) begin
                    if (tx_q.size() == 0) begin
                        check("tx_unexpected_frame", 64'(act), 64'(0));
                    end else begin
                        b = tx_q.pop_front();
                        check($sformatf("tx_frame_%02h", b), 64'(act), 64'(frame_shape(b)));
                    end
                    frames_done++;
                    prev = uart_txd;
                end else begin
                    prev = 1'b1;
                end
            end else begin
                prev = uart_txd;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b0;
        int         s0;
        int         base;
        int         p;
        int         n;

        repeat (5) @(posedge clk100);
        #1;
        reset = 1'b0;

        // Reset state
        check("txd_after_reset", 64'(uart_txd), 64'(1));
        do_read(8'h02);
        do_read(8'h03);
        do_read(8'h04);
        do_read(8'h00);
        do_read(8'hFF);

        // Unmapped write is ignored
        do_write(8'h05, 8'h3C);
        repeat (60) tick();
        check("unmapped_write_no_frame", 64'(frames_started), 64'(0));

        // Single 0x55 frame, bit timing checked by the monitor
        do_write(8'h01, 8'h55);
        wait_done(1, 200, "tx55_done");

        // Fill FIFO while byte 0 is on the wire; ninth burst byte drops
        base = frames_done;
        s0   = frames_started;
        do_write(8'h01, 8'($urandom));
        wait_started(s0 + 1, 20, "burst_first_start");
        for (int i = 0; i < 9; i++) begin
            IO_port_ID      = 8'h01;
            IO_write_data   = 8'($urandom);
            IO_write_strobe = 1'b1;
            model_push(8'h01, IO_write_data);
            tick();
        end
        IO_write_strobe = 1'b0;
        do_read(8'h03);
        wait_done(base + 9, 9 * FRAME + 100, "burst_frames_done");
        repeat (60) tick();
        check("burst_exact_frames", 64'(frames_done), 64'(base + 9));
        do_read(8'h03);

        // RX single frame
        send_rx(8'hA3, 1'b1);
        do_read(8'h02);
        do_read(8'h01);
        do_read(8'h02);

        // RX overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        do_read(8'h01);
        do_read(8'h02);
        do_read(8'h04);
        do_read(8'h04);

        // RX framing error
        send_rx(8'($urandom), 1'b0);
        do_read(8'h02);
        do_read(8'h04);

        // Short low glitch must not start a byte
        uart_rxd = 1'b0;
        repeat (2) tick();
        uart_rxd = 1'b1;
        repeat (20) tick();
        do_read(8'h02);
        do_read(8'h04);

        // Randomized mix of traffic
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 2))
                0: if (tx_level < 6) do_write(8'h01, 8'($urandom));
                1: send_rx(8'($urandom), logic'($urandom_range(0, 3) != 0));
                default: begin
                    p = $urandom_range(0, 5);
                    if (p != 3 && (p != 1 || m_rx_seen)) do_read(8'(p));
                end
            endcase
        end

        // Drain outstanding TX frames
        n = 0;
        while (tx_q.size() > 0 && n < 2000) begin
            tick();
            n++;
        end
        check("tx_drain", 64'(tx_q.size()), 64'(0));
        repeat (FRAME) tick();

        // Reset mid-frame aborts TX and flushes the FIFO
        s0 = frames_started;
        do_write(8'h01, 8'h00);
        do_write(8'h01, 8'h5A);
        wait_started(s0 + 1, 20, "rst_frame_start");
        repeat (10) tick();
        check("txd_low_before_reset", 64'(uart_txd), 64'(0));
        reset = 1'b1;
        tx_q.delete();
        tx_level    = 0;
        m_rx_valid  = 1'b0;
        m_overrun   = 1'b0;
        m_frame_err = 1'b0;
        m_rx_seen   = 1'b0;
        tick();
        check("txd_high_at_reset_edge", 64'(uart_txd), 64'(1));
        reset = 1'b0;
        do_read(8'h03);
        do_read(8'h02);
        repeat (100) tick();
        check("reset_flushes_fifo", 64'(frames_started), 64'(s0 + 1));

        check("rd_queue_empty", 64'(rd_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
